// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit for the RV32I core. Generates sequential word
// addresses, issues them on the instruction-memory request/response
// interface, buffers returned words in a 2-entry FIFO, and presents each
// word together with its PC to decode over a valid/ready handshake.
// A redirect from branch/jump resolution flushes the FIFO and marks every
// still-outstanding fetch for discard.
//
// Parameters
//   RESET_PC        first fetch address after reset (word aligned)
//
// Ports
//   clk             clock, all state on rising edge
//   rst_n           asynchronous active-low reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_addr       word-aligned fetch address (current fetch PC)
//   imem_rsp_valid  response word valid (in order)
//   imem_rsp_data   fetched instruction word
//   inst_valid      instruction available to decode
//   inst_ready      decode consumes the instruction this cycle
//   instruction     instruction word at the FIFO head
//   inst_pc         address of instruction
//   redirect_valid  branch/jump taken: flush and refetch
//   redirect_pc     new fetch address (bits [1:0] forced to zero)
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic        started_q;

    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;

    // Response FIFO: {pc, word}, 2 entries
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_word_q [2];
    logic        fifo_rd_q;
    logic        fifo_rd_d;
    logic        fifo_wr_q;
    logic        fifo_wr_d;
    logic [1:0]  fifo_cnt_q;
    logic [1:0]  fifo_cnt_d;

    // In-flight address queue: one entry per accepted, unanswered request
    logic [31:0] ifq_pc_q [2];
    logic        ifq_rd_q;
    logic        ifq_rd_d;
    logic        ifq_wr_q;
    logic        ifq_wr_d;
    logic [1:0]  outst_q;
    logic [1:0]  outst_d;

    // Number of in-flight responses that belong to a stale path
    logic [1:0]  discard_q;
    logic [1:0]  discard_d;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic        inst_pop;
    logic        req_fire;
    logic        rsp_drop;
    logic        fifo_push;
    logic [2:0]  owned;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign inst_valid  = (fifo_cnt_q != 2'd0);
    assign instruction = fifo_word_q[fifo_rd_q];
    assign inst_pc     = fifo_pc_q[fifo_rd_q];
    assign inst_pop    = inst_valid && inst_ready;

    // Words owned = buffered + in flight. The entry leaving the FIFO this
    // cycle already frees its credit, which is what lets a 1-cycle memory
    // sustain one instruction per cycle with only two credits.
    assign owned = {1'b0, fifo_cnt_q} + {1'b0, outst_q} - {2'b00, inst_pop};

    // started_q keeps the request line low while reset is held and for the
    // cycle in which reset is released.
    assign imem_req_valid = started_q && (owned < 3'd2);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is dropped when it belongs to a flushed path, or when a
    // redirect arrives in the same cycle (redirect beats any FIFO write).
    assign rsp_drop  = imem_rsp_valid && ((discard_q != 2'd0) || redirect_valid);
    assign fifo_push = imem_rsp_valid && !rsp_drop;

    // -----------------------------------------------------------------------
    // Fetch PC
    // -----------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (req_fire) begin
            // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // -----------------------------------------------------------------------
    // Outstanding / discard accounting
    // -----------------------------------------------------------------------
    always_comb begin
        outst_d = outst_q;
        case ({req_fire, imem_rsp_valid})
            2'b10:   outst_d = outst_q + 2'd1;
            2'b01:   outst_d = outst_q - 2'd1;
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        discard_d = discard_q;
        if (redirect_valid) begin
            // Everything still unanswered after this cycle, including a
            // request accepted right now to the old address, is stale.
            discard_d = outst_d;
        end else if (imem_rsp_valid && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end
    end

    // In-flight queue pointers: push on acceptance, pop on any response
    always_comb begin
        ifq_wr_d = ifq_wr_q ^ req_fire;
        ifq_rd_d = ifq_rd_q ^ imem_rsp_valid;
    end

    // -----------------------------------------------------------------------
    // Response FIFO control
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (redirect_valid) begin
            // Flush; a head consumed this cycle still completes its handshake
            fifo_rd_d  = 1'b0;
            fifo_wr_d  = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            fifo_rd_d = fifo_rd_q ^ inst_pop;
            fifo_wr_d = fifo_wr_q ^ fifo_push;
            case ({fifo_push, inst_pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            ifq_rd_q   <= 1'b0;
            ifq_wr_q   <= 1'b0;
            outst_q    <= 2'd0;
            discard_q  <= 2'd0;
        end else begin
            started_q  <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ifq_rd_q   <= ifq_rd_d;
            ifq_wr_q   <= ifq_wr_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage: cleared on reset so instruction/inst_pc read as zero
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ifq_pc_q[i] <= 32'd0;
            end
        end else if (req_fire) begin
            ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= 32'd0;
                fifo_word_q[i] <= 32'd0;
            end
        end else if (fifo_push) begin
            // The answering request is always at the in-flight queue head
            fifo_pc_q[fifo_wr_q]   <= ifq_pc_q[ifq_rd_q];
            fifo_word_q[fifo_wr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int acc_cnt = 0;
    logic stall = 1'b0;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_inst(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, ".pc"}, inst_pc, pc);
        check({tag, ".word"}, instruction, word_of(pc));
    endtask

    // One clock cycle: drive inputs after the falling edge, let outputs
    // settle, then let the memory model record any accepted request.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        cyc++;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = !stall;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
            acc_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_req_ready = 1'b0;
        stall          = 1'b0;
        #1;
        check("rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst.addr", imem_addr, 32'h0000_0100);
        check("rst.instruction", instruction, 32'd0);
        check("rst.inst_pc", inst_pc, 32'd0);
        mq_addr.delete();
        mq_due.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        cyc     = 0;
        acc_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Reset and streaming ----------------
        do_reset();
        lat = 1;
        step(1'b1, 1'b0, 32'd0);
        check("s1.c1.req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s1.c1.addr", imem_addr, 32'h100);
        check("s1.c1.inst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("s1.c2.addr", imem_addr, 32'h104);
        check("s1.c2.inst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s1.c3", 32'h100);
        check("s1.c3.addr", imem_addr, 32'h108);
        check("s1.c3.req_valid", {31'd0, imem_req_valid}, 32'd1);
        for (int k = 4; k <= 8; k++) begin
            step(1'b1, 1'b0, 32'd0);
            expect_inst("s1.stream", 32'h100 + 32'(4 * (k - 3)));
        end

        // ---------------- Backpressure ----------------
        do_reset();
        lat = 1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 32'd0);
        end
        check("s2.accepted", 32'(acc_cnt), 32'd2);
        check("s2.req_valid", {31'd0, imem_req_valid}, 32'd0);
        expect_inst("s2.hold", 32'h100);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s2.c11", 32'h100);
        check("s2.c11.req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s2.c11.addr", imem_addr, 32'h108);
        for (int k = 12; k <= 14; k++) begin
            step(1'b1, 1'b0, 32'd0);
            expect_inst("s2.resume", 32'h100 + 32'(4 * (k - 11)));
        end

        // ---------------- Redirect with two in flight ----------------
        do_reset();
        lat = 3;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_2002);
        check("s3.c3.req_valid", {31'd0, imem_req_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("s3.c4.req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("s3.c4.inst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("s3.c5.req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s3.c5.addr", imem_addr, 32'h2000);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("s3.c8.inst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s3.c9", 32'h2000);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s3.c10", 32'h2004);

        // ---------------- Handshake + redirect + response together ----------------
        do_reset();
        lat = 1;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_3000);
        expect_inst("s4.c3", 32'h100);
        check("s4.c3.rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        check("s4.c4.inst_valid", {31'd0, inst_valid}, 32'd0);
        check("s4.c4.req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s4.c4.addr", imem_addr, 32'h3000);
        step(1'b1, 1'b0, 32'd0);
        check("s4.c5.inst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s4.c6", 32'h3000);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s4.c7", 32'h3004);

        // ---------------- Memory stall, redirect during stall ----------------
        do_reset();
        lat = 1;
        stall = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        check("s5.c1.req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s5.c1.addr", imem_addr, 32'h100);
        for (int k = 2; k <= 4; k++) begin
            step(1'b1, 1'b0, 32'd0);
        end
        step(1'b1, 1'b1, 32'h0000_4000);
        check("s5.c5.req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s5.c5.addr", imem_addr, 32'h100);
        stall = 1'b0;
        step(1'b1, 1'b0, 32'd0);
        check("s5.c6.addr", imem_addr, 32'h4000);
        step(1'b1, 1'b0, 32'd0);
        check("s5.c7.addr", imem_addr, 32'h4004);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s5.c8", 32'h4000);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s5.c9", 32'h4004);

        // ---------------- Back-to-back redirects and address wrap ----------------
        do_reset();
        lat = 1;
        step(1'b1, 1'b1, 32'h0000_5000);
        step(1'b1, 1'b1, 32'hFFFF_FFFB);
        check("s6.c2.addr", imem_addr, 32'h5000);
        step(1'b1, 1'b0, 32'd0);
        check("s6.c3.addr", imem_addr, 32'hFFFF_FFF8);
        check("s6.c3.inst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("s6.c4.addr", imem_addr, 32'hFFFF_FFFC);
        check("s6.c4.inst_valid", {31'd0, inst_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s6.c5", 32'hFFFF_FFF8);
        check("s6.c5.addr", imem_addr, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s6.c6", 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'd0);
        expect_inst("s6.c7", 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
